// File: rtl/rv_issue_pkg.sv
// Shared opcode constants, queue entry type and instruction-field helpers
// used by the dual-issue front end and its pairing checker.
package rv_issue_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    // Canonical no-op: addi x0, x0, 0
    localparam logic [31:0] NOP = 32'h0000_0013;

    // One queue slot: fetch address plus the raw instruction word
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } q_entry_t;

    function automatic logic [4:0] rd_of(input logic [31:0] inst);
        return inst[11:7];
    endfunction

    function automatic logic [4:0] rs1_of(input logic [31:0] inst);
        return inst[19:15];
    endfunction

    function automatic logic [4:0] rs2_of(input logic [31:0] inst);
        return inst[24:20];
    endfunction

    // True when the instruction produces a register result other than x0.
    // Stores and branches reuse the rd bit field for immediate bits.
    function automatic logic has_rd(input logic [31:0] inst);
        logic [6:0] op;
        op = inst[6:0];
        return (op != OP_STORE) && (op != OP_BRANCH) && (inst[11:7] != 5'd0);
    endfunction

    // Every format except U and J carries a real rs1 operand
    function automatic logic reads_rs1(input logic [31:0] inst);
        logic [6:0] op;
        op = inst[6:0];
        return (op != OP_LUI) && (op != OP_AUIPC) && (op != OP_JAL);
    endfunction

    // Only R, S and B formats carry a real rs2 operand; elsewhere those
    // bits are immediate and must not create a false dependency
    function automatic logic reads_rs2(input logic [31:0] inst);
        logic [6:0] op;
        op = inst[6:0];
        return (op == OP_REG) || (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

    // Branches and jumps may redirect, so nothing may issue beside them
    function automatic logic is_ctrl(input logic [31:0] inst);
        logic [6:0] op;
        op = inst[6:0];
        return (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
    endfunction

endpackage

// File: rtl/issue_dep_check.sv
// Pairing test for the two head-of-queue instructions: the bta candidate may
// issue alongside alp only when it neither consumes alp's result nor follows
// a control-flow instruction.
module issue_dep_check
    import rv_issue_pkg::*;
(
    input  logic [31:0] inst_alp,
    input  logic [31:0] inst_bta,
    output logic        pair_ok
);

    logic raw_rs1;
    logic raw_rs2;
    logic ctrl_hazard;

    // Hazard detection; the result is a pure function of the two words
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
        raw_rs1     = 1'b0;
        raw_rs2     = 1'b0;
        ctrl_hazard = is_ctrl(inst_alp);
        if (has_rd(inst_alp)) begin
            raw_rs1 = reads_rs1(inst_bta) && (rs1_of(inst_bta) == rd_of(inst_alp));
            raw_rs2 = reads_rs2(inst_bta) && (rs2_of(inst_bta) == rd_of(inst_alp));
        end
        pair_ok = !(raw_rs1 || raw_rs2 || ctrl_hazard);
    end

endmodule

// File: rtl/dual_issue_scheduler.sv
// Two-way front end: fetches instruction pairs into a circular queue and
// issues one or two per cycle from its head to the alp/bta slots.
module dual_issue_scheduler
    import rv_issue_pkg::*;
#(
    parameter int          QDEPTH   = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ACKI_n,
    input  logic [31:0] IDT1,
    input  logic [31:0] IDT2,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] IAD,
    output logic        fetch_req,
    output logic [31:0] inst_alp,
    output logic [31:0] inst_bta,
    output logic [31:0] pc_alp,
    output logic [31:0] pc_bta,
    output logic        valid_alp,
    output logic        valid_bta,
    output logic        is_plus8
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Fetch only while a whole pair still fits, judged before this cycle's pops
    localparam logic [CNT_W-1:0] FETCH_LIMIT = CNT_W'(QDEPTH - 2);

    q_entry_t         queue_mem [QDEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic [31:0] pc_alp_q;
    logic [31:0] pc_bta_q;

    logic             enq;
    logic             pair_ok;
    logic [PTR_W-1:0] head_next1;
    logic [PTR_W-1:0] tail_next1;
    logic [CNT_W-1:0] push_n;
    logic [CNT_W-1:0] pop_n;
    q_entry_t         entry_alp;
    q_entry_t         entry_bta;

    assign head_next1 = head + PTR_W'(1);
    assign tail_next1 = tail + PTR_W'(1);
    assign entry_alp  = queue_mem[head];
    assign entry_bta  = queue_mem[head_next1];

    issue_dep_check u_dep_check (
        .inst_alp (entry_alp.inst),
        .inst_bta (entry_bta.inst),
        .pair_ok  (pair_ok)
    );

    // Fetch request and enqueue qualification; redirect silences fetch
    always_comb begin
        fetch_req = (count <= FETCH_LIMIT) && !redirect;
        enq       = fetch_req && !ACKI_n;
        push_n    = enq ? CNT_W'(2) : '0;
    end

    // Issue selection from the queue head; stall or redirect suppress issue
    // while pc_* keep showing the head (or the last shown value when empty)
    always_comb begin
        valid_alp = 1'b0;
        valid_bta = 1'b0;
        inst_alp  = NOP;
        inst_bta  = NOP;
        pc_alp    = pc_alp_q;
        pc_bta    = pc_bta_q;
        if (count != '0) begin
            pc_alp = entry_alp.pc;
            if (!stall && !redirect) begin
                valid_alp = 1'b1;
                inst_alp  = entry_alp.inst;
            end
        end
        if (count >= CNT_W'(2)) begin
            pc_bta = entry_bta.pc;
            if (!stall && !redirect && pair_ok) begin
                valid_bta = 1'b1;
                inst_bta  = entry_bta.inst;
            end
        end
        is_plus8 = valid_alp && valid_bta;
        pop_n    = CNT_W'(valid_alp) + CNT_W'(valid_bta);
    end

    // Queue bookkeeping and fetch PC; redirect wins over enqueue and dequeue
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            IAD      <= RESET_PC;
            pc_alp_q <= '0;
            pc_bta_q <= '0;
        end else begin
            pc_alp_q <= pc_alp;
            pc_bta_q <= pc_bta;
            if (redirect) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
                IAD   <= redirect_pc;
            end else begin
                head  <= head + pop_n[PTR_W-1:0];
                count <= count + push_n - pop_n;
                if (enq) begin
                    tail <= tail + PTR_W'(2);
                    IAD  <= IAD + 32'd8;
                end
            end
        end
    end

    // Queue storage writes; both halves of an acknowledged pair land together
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; count/head/tail gate every read, so stale contents are never visible.
        if (enq) begin
            queue_mem[tail]       <= '{pc: IAD,          inst: IDT1};
            queue_mem[tail_next1] <= '{pc: IAD + 32'd4,  inst: IDT2};
        end
    end

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Directed bench for dual_issue_scheduler with hand-computed expectations.
module tb_dual_issue_scheduler;

    localparam logic [31:0] NOP_W      = 32'h0000_0013;
    localparam logic [31:0] ADDI_X1_1  = 32'h0010_0093; // addi x1,x0,1
    localparam logic [31:0] ADDI_X2_2  = 32'h0020_0113; // addi x2,x0,2
    localparam logic [31:0] ADD_X3_12  = 32'h0020_81B3; // add  x3,x1,x2
    localparam logic [31:0] ADDI_X0_5  = 32'h0050_0013; // addi x0,x0,5
    localparam logic [31:0] ADD_X3_00  = 32'h0000_01B3; // add  x3,x0,x0
    localparam logic [31:0] LW_X5      = 32'h0000_A283; // lw   x5,0(x1)
    localparam logic [31:0] ADDI_X6_X7 = 32'h0053_8313; // addi x6,x7,5 (rs2 field = 5)
    localparam logic [31:0] BEQ_X1_X2  = 32'h0020_8063; // beq  x1,x2,0
    localparam logic [31:0] ADDI_X4_4  = 32'h0040_0213; // addi x4,x0,4

    logic        clk = 1'b0;
    logic        rst;
    logic        ACKI_n;
    logic [31:0] IDT1;
    logic [31:0] IDT2;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] IAD;
    logic        fetch_req;
    logic [31:0] inst_alp;
    logic [31:0] inst_bta;
    logic [31:0] pc_alp;
    logic [31:0] pc_bta;
    logic        valid_alp;
    logic        valid_bta;
    logic        is_plus8;

    int n_cmp = 0;
    int n_err = 0;

    dual_issue_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .ACKI_n      (ACKI_n),
        .IDT1        (IDT1),
        .IDT2        (IDT2),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .IAD         (IAD),
        .fetch_req   (fetch_req),
        .inst_alp    (inst_alp),
        .inst_bta    (inst_bta),
        .pc_alp      (pc_alp),
        .pc_bta      (pc_bta),
        .valid_alp   (valid_alp),
        .valid_bta   (valid_bta),
        .is_plus8    (is_plus8)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic ack_n, input logic [31:0] w1, input logic [31:0] w2);
        ACKI_n = ack_n;
        IDT1   = w1;
        IDT2   = w2;
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        offer(1'b1, NOP_W, NOP_W);

        // Reset state
        #2;
        check("rst_valid_alp", 32'(valid_alp), 32'd0);
        check("rst_valid_bta", 32'(valid_bta), 32'd0);
        check("rst_inst_alp",  inst_alp, NOP_W);
        check("rst_inst_bta",  inst_bta, NOP_W);
        check("rst_iad",       IAD, 32'h0);
        check("rst_pc_alp",    pc_alp, 32'h0);
        #10 rst = 1'b1;
        tick();
        check("post_rst_fetch_req", 32'(fetch_req), 32'd1);

        // 1: independent pair at pc 0
        offer(1'b0, ADDI_X1_1, ADDI_X2_2);
        #1;
        check("t1_iad", IAD, 32'h0);
        tick();
        offer(1'b1, NOP_W, NOP_W);
        #1;
        check("t1_valid_alp", 32'(valid_alp), 32'd1);
        check("t1_valid_bta", 32'(valid_bta), 32'd1);
        check("t1_plus8",     32'(is_plus8), 32'd1);
        check("t1_pc_alp",    pc_alp, 32'h0);
        check("t1_pc_bta",    pc_bta, 32'h4);
        check("t1_inst_bta",  inst_bta, ADDI_X2_2);
        check("t1_iad_next",  IAD, 32'h8);
        tick();

        // 2: RAW hazard holds the add for one cycle; empty queue holds pc
        offer(1'b0, ADDI_X1_1, ADD_X3_12);
        #1;
        check("empty_valid_alp", 32'(valid_alp), 32'd0);
        check("empty_pc_hold",   pc_alp, 32'h0);
        tick();
        offer(1'b1, NOP_W, NOP_W);
        #1;
        check("t2_c1_inst_alp", inst_alp, ADDI_X1_1);
        check("t2_c1_pc_alp",   pc_alp, 32'h8);
        check("t2_c1_valid_bta", 32'(valid_bta), 32'd0);
        check("t2_c1_inst_bta", inst_bta, NOP_W);
        tick();
        check("t2_c2_inst_alp", inst_alp, ADD_X3_12);
        check("t2_c2_pc_alp",   pc_alp, 32'hC);
        check("t2_c2_valid_bta", 32'(valid_bta), 32'd0);
        tick();

        // 3: no false dependencies (x0 destination, immediate in rs2 field)
        offer(1'b0, ADDI_X0_5, ADD_X3_00);
        tick();
        offer(1'b0, LW_X5, ADDI_X6_X7);
        #1;
        check("t3a_plus8",  32'(is_plus8), 32'd1);
        check("t3a_pc_alp", pc_alp, 32'h10);
        tick();
        offer(1'b1, NOP_W, NOP_W);
        #1;
        check("t3b_plus8",    32'(is_plus8), 32'd1);
        check("t3b_pc_alp",   pc_alp, 32'h18);
        check("t3b_inst_bta", inst_bta, ADDI_X6_X7);
        tick();

        // 4: branch in alp holds bta; then redirect with three entries queued
        offer(1'b0, BEQ_X1_X2, ADDI_X4_4);
        tick();
        offer(1'b0, ADDI_X1_1, ADDI_X2_2);
        #1;
        check("t4_inst_alp",  inst_alp, BEQ_X1_X2);
        check("t4_valid_bta", 32'(valid_bta), 32'd0);
        tick();
        redirect = 1'b1; redirect_pc = 32'h100;
        #1;
        check("t4_redir_valid_alp", 32'(valid_alp), 32'd0);
        check("t4_redir_inst_alp",  inst_alp, NOP_W);
        check("t4_redir_fetch_req", 32'(fetch_req), 32'd0);
        check("t4_redir_iad_before", IAD, 32'h30);
        tick();
        redirect = 1'b0;
        offer(1'b1, NOP_W, NOP_W);
        #1;
        check("t4_iad_retarget", IAD, 32'h100);
        check("t4_flush_valid",  32'(valid_alp), 32'd0);
        check("t4_fetch_req",    32'(fetch_req), 32'd1);

        // 5: back-pressure fills the queue then drains in order
        stall = 1'b1;
        offer(1'b0, ADDI_X1_1, ADDI_X2_2);
        tick();
        offer(1'b0, ADDI_X0_5, ADD_X3_00);
        #1;
        check("t5_stall_valid", 32'(valid_alp), 32'd0);
        check("t5_fetch_at_2",  32'(fetch_req), 32'd1);
        tick();
        offer(1'b0, BEQ_X1_X2, BEQ_X1_X2);
        #1;
        check("t5_full_fetch_req", 32'(fetch_req), 32'd0);
        tick();
        check("t5_iad_frozen", IAD, 32'h110);
        tick();
        stall = 1'b0;
        offer(1'b1, NOP_W, NOP_W);
        #1;
        check("t5_r1_pc_alp",    pc_alp, 32'h100);
        check("t5_r1_inst_alp",  inst_alp, ADDI_X1_1);
        check("t5_r1_plus8",     32'(is_plus8), 32'd1);
        check("t5_r1_fetch_req", 32'(fetch_req), 32'd0);
        tick();
        check("t5_r2_pc_alp",   pc_alp, 32'h108);
        check("t5_r2_inst_bta", inst_bta, ADD_X3_00);
        check("t5_r2_plus8",    32'(is_plus8), 32'd1);
        tick();

        // 6: asynchronous reset mid-stream, off the clock edge
        offer(1'b0, ADDI_X1_1, ADDI_X2_2);
        tick();
        offer(1'b1, NOP_W, NOP_W);
        #1;
        check("t6_pre_pc_alp", pc_alp, 32'h110);
        #2 rst = 1'b0;
        #1;
        check("t6_valid_alp", 32'(valid_alp), 32'd0);
        check("t6_inst_alp",  inst_alp, NOP_W);
        check("t6_iad",       IAD, 32'h0);
        check("t6_pc_alp",    pc_alp, 32'h0);
        #2 rst = 1'b1;
        tick();
        check("t6_after_valid",     32'(valid_alp), 32'd0);
        check("t6_after_fetch_req", 32'(fetch_req), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
